// File: rtl/pipeline_stall_control_pkg.sv
// Shared pipeline package for the stall/flush control block.
// Holds the controller state encoding, the hard-wired zero register
// number and the default multiply/divide front-end stall length.
package pipeline_stall_control_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Register number that is hard-wired to zero and never creates a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Total front-end stall cycles per multiply/divide (legal 2..8).
  localparam int MULDIV_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/pipeline_stall_control_load_use_detect.sv
// Load-use hazard comparator.
// Flags when the load in EX writes a register that the ID-stage
// instruction reads. Register 0 never produces a hazard.
// Ports:
//   mem_read  : EX-stage instruction is a load
//   ex_rt     : load destination register in EX
//   id_rs     : ID-stage source register Rs
//   id_rt     : ID-stage source register Rt
//   load_use  : hazard detected (purely combinational)
module load_use_detect
  import pipeline_stall_control_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_stall_control.sv
// Pipeline stall / flush controller.
// Stalls the front end for load-use hazards (one cycle) and for
// multi-cycle multiply/divide (MULDIV_LATENCY cycles including the start
// cycle), flushes IF/ID on taken branches and jumps, and counts stalled
// cycles with a saturating counter.
// Priority: MD_BUSY state > MulDiv_Start > load_use > Branch_Taken/Jump.
// Lower-priority events are dropped, never queued.
// Ports:
//   clk, reset (async, active-low)
//   ID_EX_MemRead, ID_EX_RegisterRt : EX-stage load info
//   IF_ID_RegisterRs/Rt             : ID-stage source registers
//   MulDiv_Start                    : EX-stage multi-cycle multiply/divide
//   Branch_Taken, Jump              : ID-stage control transfer
//   PC_Write, IF_ID_Write           : load enables (0 = hold)
//   ID_EX_Bubble                    : zero all ID/EX control bits
//   IF_ID_Flush                     : turn IF/ID instruction into a NOP
//   MD_Busy                         : multi-cycle unit occupies EX
//   Stall_Count                     : saturating count of PC_Write=0 cycles
//   debug_state                     : current controller state (observation)
module pipeline_stall_control
  import pipeline_stall_control_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        MulDiv_Start,
  input  logic        Branch_Taken,
  input  logic        Jump,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        MD_Busy,
  output logic [15:0] Stall_Count,
  output state_t      debug_state
);

  // The start cycle is one stall cycle, and MD_BUSY lasts md_cnt+1 cycles,
  // so loading LATENCY-2 yields exactly LATENCY stall cycles in total.
  localparam logic [2:0] MD_CNT_INIT = 3'(MULDIV_LATENCY - 2);

  state_t     state;
  logic [2:0] md_cnt;
  logic       load_use;

  load_use_detect u_load_use_detect (
    .mem_read (ID_EX_MemRead),
    .ex_rt    (ID_EX_RegisterRt),
    .id_rs    (IF_ID_RegisterRs),
    .id_rt    (IF_ID_RegisterRt),
    .load_use (load_use)
  );

  // State and multiply/divide down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      md_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MulDiv_Start) begin
            state  <= MD_BUSY;
            md_cnt <= MD_CNT_INIT;
          end
        end
        MD_BUSY: begin
          if (md_cnt == 3'd0) begin
            state <= IDLE;
          end else begin
            md_cnt <= md_cnt - 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          md_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Control outputs. Gated by reset so inputs held during reset cannot
  // produce a stall or flush while the controller is being cleared.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    MD_Busy      = 1'b0;
    if (reset) begin
      if ((state == MD_BUSY) || MulDiv_Start) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        MD_Busy      = 1'b1;
      end else if (load_use) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if (Branch_Taken || Jump) begin
        IF_ID_Flush  = 1'b1;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Count <= 16'd0;
    end else if (!PC_Write && (Stall_Count != 16'hFFFF)) begin
      Stall_Count <= Stall_Count + 16'd1;
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Self-checking bench for pipeline_stall_control.
module tb_pipeline_stall_control;
  import pipeline_stall_control_pkg::*;

  localparam int LAT = 4;
  localparam int W   = 22; // {state, PC_Write, IF_ID_Write, Bubble, Flush, MD_Busy, Stall_Count}

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt;
  logic [4:0]  IF_ID_RegisterRs;
  logic [4:0]  IF_ID_RegisterRt;
  logic        MulDiv_Start;
  logic        Branch_Taken;
  logic        Jump;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_Bubble;
  logic        IF_ID_Flush;
  logic        MD_Busy;
  logic [15:0] Stall_Count;
  state_t      debug_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_rem = 0;   // MD_BUSY cycles still to come
  int m_cnt = 0;   // expected Stall_Count

  pipeline_stall_control #(.MULDIV_LATENCY(LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRt (ID_EX_RegisterRt),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .MulDiv_Start     (MulDiv_Start),
    .Branch_Taken     (Branch_Taken),
    .Jump             (Jump),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .IF_ID_Flush      (IF_ID_Flush),
    .MD_Busy          (MD_Busy),
    .Stall_Count      (Stall_Count),
    .debug_state      (debug_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    m_rem = 0;
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Driver: called 1 time unit after a rising edge. Drives one cycle of
  // inputs, pushes the expected outputs, compares at the falling edge and
  // advances the model across the next rising edge.
  task automatic drive_cycle(input string tag, input logic mr, input logic [4:0] ex_rt,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic st, input logic br, input logic jp);
    logic         lu;
    logic [4:0]   e_out;
    int           next_rem;
    logic [W-1:0] e;
    logic [W-1:0] got;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = ex_rt;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    MulDiv_Start     = st;
    Branch_Taken     = br;
    Jump             = jp;
    lu = mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
    next_rem = m_rem;
    if (m_rem > 0) begin
      e_out = 5'b00101;
      next_rem = m_rem - 1;
    end else if (st) begin
      e_out = 5'b00101;
      next_rem = LAT - 1;
    end else if (lu) begin
      e_out = 5'b00100;
    end else if (br || jp) begin
      e_out = 5'b11010;
    end else begin
      e_out = 5'b11000;
    end
    exp_q.push_back({(m_rem > 0), e_out, 16'(m_cnt)});
    @(negedge clk);
    e   = exp_q.pop_front();
    got = {debug_state == MD_BUSY, PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
           MD_Busy, Stall_Count};
    checks++;
    if (got[21:16] !== e[21:16]) begin
      errors++;
      $display("FAIL %s ctrl {state,pcw,ifw,bub,flush,busy} got %b exp %b",
               tag, got[21:16], e[21:16]);
    end
    checks++;
    if (got[15:0] !== e[15:0]) begin
      errors++;
      $display("FAIL %s stall_count got %0d exp %0d", tag, got[15:0], e[15:0]);
    end
    @(posedge clk);
    #1;
    m_rem = next_rem;
    if (!e_out[4] && m_cnt < 65535) m_cnt = m_cnt + 1;
  endtask

  task automatic idle_cycle(input string tag);
    drive_cycle(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // Hostile inputs held during reset must not leak to the outputs.
    ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd3;
    IF_ID_RegisterRs = 5'd3; IF_ID_RegisterRt = 5'd0;
    MulDiv_Start = 1'b1; Branch_Taken = 1'b1; Jump = 1'b1;
    reset = 1'b0;
    #3;
    checks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MD_Busy} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outs got %b exp %b",
               {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MD_Busy}, 5'b11000);
    end
    checks++;
    if (Stall_Count !== 16'd0 || debug_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state count %0d state %0d exp 0 0", Stall_Count, debug_state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Stall_Count !== 16'd0 || MD_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold count %0d busy %b exp 0 0", Stall_Count, MD_Busy);
    end
    MulDiv_Start = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0; ID_EX_MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_rem = 0;
    m_cnt = 0;
    idle_cycle("reset_idle");
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_cycle("lu_rs", 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    drive_cycle("lu_after", 1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Stall_Count !== 16'd1) begin
      errors++;
      $display("FAIL lu_count got %0d exp 1", Stall_Count);
    end
    drive_cycle("lu_rt", 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    drive_cycle("lu_nomatch", 1'b1, 5'd7, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0);
    drive_cycle("lu_noread", 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reg_zero();
    apply_reset();
    drive_cycle("r0_rs", 1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    drive_cycle("r0_rt", 1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Stall_Count !== 16'd0) begin
      errors++;
      $display("FAIL r0_count got %0d exp 0", Stall_Count);
    end
  endtask

  task automatic test_muldiv();
    apply_reset();
    drive_cycle("md_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle_cycle("md_run");
    checks++;
    if (Stall_Count !== 16'(LAT)) begin
      errors++;
      $display("FAIL md_count got %0d exp %0d", Stall_Count, LAT);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    drive_cycle("pri_lu_br", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    drive_cycle("pri_lu_jmp", 1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
    drive_cycle("pri_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive_cycle("pri_jmp", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive_cycle("pri_md_lu_br", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    drive_cycle("pri_busy_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive_cycle("pri_busy_st", 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
    drive_cycle("pri_busy_jmp", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive_cycle("pri_after", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive_cycle("b2b_md1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LAT - 1; i++) idle_cycle("b2b_run1");
    drive_cycle("b2b_md2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LAT - 1; i++) idle_cycle("b2b_run2");
    drive_cycle("b2b_lu1", 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_cycle("b2b_lu2", 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
    idle_cycle("b2b_end");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_cycle("rm_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle_cycle("rm_busy1");
    // Now inside the second MD_BUSY cycle.
    reset = 1'b0;
    #1;
    checks++;
    if ({MD_Busy, PC_Write, Stall_Count, debug_state == MD_BUSY} !== {1'b0, 1'b1, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL rm_async busy %b pcw %b count %0d state %0d exp 0 1 0 0",
               MD_Busy, PC_Write, Stall_Count, debug_state);
    end
    m_rem = 0;
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle("rm_idle");
    drive_cycle("rm_restart", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) idle_cycle("rm_run");
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      drive_cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 65534; i++)
      drive_cycle("sat_fill", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Stall_Count !== 16'd65534) begin
      errors++;
      $display("FAIL sat_preload got %0d exp 65534", Stall_Count);
    end
    for (int i = 0; i < 3; i++)
      drive_cycle("sat_top", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Stall_Count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final got %h exp ffff", Stall_Count);
    end
    idle_cycle("sat_hold");
  endtask

  initial begin
    reset = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0;
    MulDiv_Start = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0;
    test_reset();
    test_load_use();
    test_reg_zero();
    test_muldiv();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_control.md
PIPELINE_STALL_CONTROL -- requirements
Module: pipeline_stall_control

Interface
REQ-001 Parameter MULDIV_LATENCY, default 4, meaning total front-end stall cycles per multiply/divide (legal 2..8).
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ID_EX_MemRead  input  1  EX-stage instruction is a load.
REQ-005 ID_EX_RegisterRt  input  5  load destination register in EX.
REQ-006 IF_ID_RegisterRs  input  5  source register Rs of the ID-stage instruction.
REQ-007 IF_ID_RegisterRt  input  5  source register Rt of the ID-stage instruction.
REQ-008 MulDiv_Start  input  1  EX-stage instruction is a multi-cycle multiply/divide.
REQ-009 Branch_Taken  input  1  branch resolved taken in ID.
REQ-010 Jump  input  1  jump decoded in ID.
REQ-011 PC_Write  output  1  PC load enable (0 = hold PC).
REQ-012 IF_ID_Write  output  1  IF/ID register load enable (0 = hold).
REQ-013 ID_EX_Bubble  output  1  force all ID/EX control bits to zero.
REQ-014 IF_ID_Flush  output  1  clear IF/ID instruction to NOP.
REQ-015 MD_Busy  output  1  multi-cycle unit occupying EX.
REQ-016 Stall_Count  output  16  saturating count of cycles with PC_Write=0.

Function
REQ-017 States: IDLE, MD_BUSY; 3-bit down-counter md_cnt.
REQ-018 load_use = ID_EX_MemRead & (ID_EX_RegisterRt != 0) & (ID_EX_RegisterRt == IF_ID_RegisterRs | ID_EX_RegisterRt == IF_ID_RegisterRt); combinational, same cycle.
REQ-019 IDLE, MulDiv_Start=1: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, MD_Busy=1; md_cnt <= MULDIV_LATENCY-2; next state MD_BUSY.
REQ-020 MD_BUSY: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, MD_Busy=1; md_cnt decrements; when md_cnt==0 next state IDLE.
REQ-021 Total front-end stall per multiply/divide is exactly MULDIV_LATENCY cycles, counting the MulDiv_Start cycle.
REQ-022 MulDiv_Start, load_use, Branch_Taken, Jump ignored in MD_BUSY.
REQ-023 IDLE, MulDiv_Start=0, load_use=1: one-cycle stall: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0; state stays IDLE.
REQ-024 IDLE, no stall, (Branch_Taken | Jump)=1: IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
REQ-025 IDLE, no condition: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, MD_Busy=0.
REQ-026 Priority: MD_BUSY state > MulDiv_Start > load_use > Branch_Taken/Jump; a lower-priority event is suppressed, not queued.
REQ-027 Register 0 never causes a load-use stall.
REQ-028 Stall_Count increments by 1 each cycle PC_Write=0; saturates at 16'hFFFF, no wrap.
REQ-029 All outputs except Stall_Count and MD_Busy in MD_BUSY are combinational from state, counter, and inputs; no added latency.

Reset
REQ-030 reset=0 forces state IDLE, md_cnt=0, Stall_Count=0 immediately, without a clock edge.
REQ-031 While reset=0: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, MD_Busy=0.
REQ-032 Reset asserted mid-MD_BUSY aborts the stall; the first edge after release evaluates from IDLE.

Structure
REQ-033 The shared pipeline package holds the state encoding (IDLE=1'b0, MD_BUSY=1'b1), the register-0 constant, and the MULDIV_LATENCY default.
REQ-034 Single module; the load_use comparator is a natural sub-module named load_use_detect.

Verification
REQ-035 Load-use: ID_EX_MemRead=1, Rt=5, IF_ID Rs=5 -> one cycle PC_Write=0, ID_EX_Bubble=1; next cycle (MemRead=0) PC_Write=1; Stall_Count=1.
REQ-036 Register 0: ID_EX_MemRead=1, Rt=0, IF_ID Rs=0 -> no stall, PC_Write=1.
REQ-037 MulDiv default latency: MulDiv_Start pulse for 1 cycle -> PC_Write=0 for exactly 4 cycles, MD_Busy=1 for the same 4 cycles, Stall_Count=4.
REQ-038 Priority: load_use=1 and Branch_Taken=1 together -> IF_ID_Flush=0, stall taken; Branch_Taken during MD_BUSY -> IF_ID_Flush=0.
REQ-039 Reset mid-operation: reset=0 in the 2nd MD_BUSY cycle -> MD_Busy=0, PC_Write=1, Stall_Count=0 asynchronously.
REQ-040 Saturation: preload by forcing 65534 stall cycles, then 3 more stall cycles -> Stall_Count=16'hFFFF, no wrap.
